// File: rtl/uart_rx_mmio_if.sv
// uart_rx_mmio_if: native processor memory-bus bundle for the UART receiver page.
//   mem_addr  [31:0]  byte address (master -> slave)
//   mem_wdata [31:0]  write data (master -> slave)
//   mem_wmask [3:0]   byte write enables, nonzero means write (master -> slave)
//   mem_rstrb         one-cycle read strobe (master -> slave)
//   mem_rdata [31:0]  registered read data, zero when not being read (slave -> master)
interface uart_rx_mmio_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rstrb;
    logic [31:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_wmask,
        output mem_rstrb,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_wmask,
        input  mem_rstrb,
        output mem_rdata
    );
endinterface

// File: rtl/uart_rx_mmio.sv
// uart_rx_mmio: memory-mapped 8N1 UART receiver with a small receive FIFO.
//   clk      system clock, rising edge
//   reset    synchronous active-high reset
//   bus      uart_rx_mmio_if.slave (mem_addr/wdata/wmask/rstrb in, mem_rdata out)
//   rxd      asynchronous serial input, idle high
//   rx_irq   FIFO non-empty and CTRL.irq_en
//   rx_busy  receiver FSM not idle
// Register page (word offset mem_addr[3:2]):
//   0x0 DATA   R    {23'b0, nonempty, head_byte}; a read pops when non-empty
//   0x4 STATUS R/W1C {24'b0, count[3:0], frame_err, overrun, full, nonempty}
//                    write bit2 clears overrun, bit3 clears frame_err
//   0x8 CTRL   R/W  bit0 enable, bit1 irq_en
//   0xC        reads 0, writes ignored
//
// Receiver FSM:
//   state | meaning
//   IDLE  | waiting for a falling edge on the synchronized line
//   START | counting half a bit to re-check the start bit in its middle
//   DATA  | sampling 8 data bits, LSB first, one per bit period
//   STOP  | sampling the stop bit; push on 1, frame error on 0
module uart_rx_mmio #(
    parameter int          CLK_FREQ_HZ = 12000000,
    parameter int          BAUD_RATE   = 9600,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [31:0] BASE_ADDR   = 32'h2000_2000
) (
    input  logic           clk,
    input  logic           reset,
    uart_rx_mmio_if.slave  bus,
    input  logic           rxd,
    output logic           rx_irq,
    output logic           rx_busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT) + 1;
    localparam int AW           = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);
    localparam logic [3:0]    DEPTH4   = 4'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // input synchronizer and edge detect
    logic rx_meta, rx_s, rx_d;
    logic start_det;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    assign start_det = rx_d & ~rx_s;

    // receiver FSM
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shift_reg, shift_n;
    logic          push_req;
    logic          frame_set;
    logic          enable;
    logic          irq_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_idx_n;
            shift_reg <= shift_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shift_n   = shift_reg;
        push_req  = 1'b0;
        frame_set = 1'b0;
        if (!enable) begin
            // disabling abandons any partial frame
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start_det) begin
                        state_n = START;
                        cnt_n   = CNT_HALF;
                    end
                end
                START: begin
                    if (cnt == '0) begin
                        if (!rx_s) begin
                            state_n   = DATA;
                            cnt_n     = CNT_BIT;
                            bit_idx_n = 3'd0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        cnt_n = cnt - CW'(1);
                    end
                end
                DATA: begin
                    if (cnt == '0) begin
                        shift_n = {rx_s, shift_reg[7:1]};
                        cnt_n   = CNT_BIT;
                        if (bit_idx == 3'd7) begin
                            state_n = STOP;
                        end else begin
                            bit_idx_n = bit_idx + 3'd1;
                        end
                    end else begin
                        cnt_n = cnt - CW'(1);
                    end
                end
                STOP: begin
                    if (cnt == '0) begin
                        if (rx_s) push_req  = 1'b1;
                        else      frame_set = 1'b1;
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt - CW'(1);
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // bus decode
    logic        sel;
    logic [1:0]  offs;
    logic        rd_en;
    logic        status_wr;
    logic        ctrl_wr;

    assign sel       = (bus.mem_addr[31:12] == BASE_ADDR[31:12]);
    assign offs      = bus.mem_addr[3:2];
    assign rd_en     = sel & bus.mem_rstrb;
    assign status_wr = sel & bus.mem_wmask[0] & (offs == 2'd1);
    assign ctrl_wr   = sel & bus.mem_wmask[0] & (offs == 2'd2);

    // FIFO
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [3:0]    count;
    logic          nonempty, full;
    logic          pop, push_ok, overrun_set;
    logic          overrun, frame_err;

    assign nonempty = (count != 4'd0);
    assign full     = (count == DEPTH4);
    assign pop      = rd_en & (offs == 2'd0) & nonempty;
    // a simultaneous pop frees the slot, so a full FIFO still accepts the byte
    assign push_ok     = push_req & (~full | pop);
    assign overrun_set = push_req & full & ~pop;

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= shift_reg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= 4'd0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            enable    <= 1'b1;
            irq_en    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
            // set has priority over a same-cycle write-1-to-clear
            overrun   <= overrun_set | (overrun & ~(status_wr & bus.mem_wdata[2]));
            frame_err <= frame_set | (frame_err & ~(status_wr & bus.mem_wdata[3]));
            if (ctrl_wr) begin
                enable <= bus.mem_wdata[0];
                irq_en <= bus.mem_wdata[1];
            end
        end
    end

    // read data: value reflects pre-pop head, returned one cycle after the strobe
    logic [31:0] rd_val;

    always_comb begin
        rd_val = 32'd0;
        case (offs)
            2'd0:    rd_val = nonempty ? {23'd0, 1'b1, fifo_mem[rd_ptr]} : 32'd0;
            2'd1:    rd_val = {24'd0, count, frame_err, overrun, full, nonempty};
            2'd2:    rd_val = {30'd0, irq_en, enable};
            default: rd_val = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) bus.mem_rdata <= 32'd0;
        else       bus.mem_rdata <= rd_en ? rd_val : 32'd0;
    end

    assign rx_irq  = nonempty & irq_en;
    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_mmio.sv
module tb_uart_rx_mmio;
    localparam int          CLK_HZ = 1000000;
    localparam int          BAUD   = 100000;
    localparam int          CPB    = 10;
    localparam int          HALF   = 5;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] BASE   = 32'h2000_2000;

    logic clk = 1'b0;
    logic reset;
    logic rxd;
    logic rx_irq;
    logic rx_busy;

    uart_rx_mmio_if bus();

    uart_rx_mmio #(
        .CLK_FREQ_HZ(CLK_HZ),
        .BAUD_RATE  (BAUD),
        .FIFO_DEPTH (DEPTH),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus.slave),
        .rxd    (rxd),
        .rx_irq (rx_irq),
        .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: software-visible state only
    byte unsigned mq[$];
    bit m_ov, m_fe, m_en, m_ien;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        mq.delete();
        m_ov  = 1'b0;
        m_fe  = 1'b0;
        m_en  = 1'b1;
        m_ien = 1'b0;
    endfunction

    function automatic logic [31:0] m_status();
        logic [31:0] v;
        v      = 32'd0;
        v[7:4] = 4'(mq.size());
        v[3]   = m_fe;
        v[2]   = m_ov;
        v[1]   = (mq.size() == DEPTH);
        v[0]   = (mq.size() != 0);
        return v;
    endfunction

    function automatic logic [31:0] m_pop();
        logic [31:0] v;
        v = 32'd0;
        if (mq.size() != 0) v = {23'd0, 1'b1, mq.pop_front()};
        return v;
    endfunction

    function automatic void m_frame(input byte unsigned b, input bit stop_ok);
        if (!m_en) return;
        if (!stop_ok)                m_fe = 1'b1;
        else if (mq.size() == DEPTH) m_ov = 1'b1;
        else                         mq.push_back(b);
    endfunction

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        bus.mem_addr  = addr;
        bus.mem_rstrb = 1'b1;
        @(posedge clk); #1;
        bus.mem_rstrb = 1'b0;
        data = bus.mem_rdata;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] wdata);
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
        bus.mem_wmask = 4'h1;
        @(posedge clk); #1;
        bus.mem_wmask = 4'h0;
    endtask

    task automatic rd_data(input string tag);
        logic [31:0] d;
        bus_read(BASE + 32'h0, d);
        check(tag, d, m_pop());
    endtask

    task automatic rd_status(input string tag);
        logic [31:0] d;
        bus_read(BASE + 32'h4, d);
        check(tag, d, m_status());
    endtask

    task automatic rd_ctrl(input string tag);
        logic [31:0] d;
        bus_read(BASE + 32'h8, d);
        check(tag, d, {30'd0, m_ien, m_en});
    endtask

    task automatic wr_status(input logic [31:0] v);
        bus_write(BASE + 32'h4, v);
        if (v[2]) m_ov = 1'b0;
        if (v[3]) m_fe = 1'b0;
    endtask

    task automatic wr_ctrl(input logic [31:0] v);
        bus_write(BASE + 32'h8, v);
        m_en  = v[0];
        m_ien = v[1];
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // drives one 8N1 frame, one iteration per clock; optionally strobes a DATA
    // read so it lands in the stop-sample cycle, or pulses reset mid-frame
    task automatic send_frame(input byte unsigned b, input bit stop_val, input bit pop_at_stop,
                              input int abort_at, output logic [31:0] popped);
        logic [9:0] bits;
        bits   = {stop_val, b, 1'b0};
        popped = 32'd0;
        for (int i = 0; i < 10 * CPB; i++) begin
            rxd = bits[i / CPB];
            if (i == abort_at) begin
                reset = 1'b1;
                @(posedge clk); @(posedge clk); #1;
                reset = 1'b0;
                rxd   = 1'b1;
                return;
            end
            if (pop_at_stop && i == 10 * CPB - 3) begin
                bus.mem_addr  = BASE;
                bus.mem_rstrb = 1'b1;
            end
            @(posedge clk); #1;
            if (bus.mem_rstrb) begin
                bus.mem_rstrb = 1'b0;
                popped = bus.mem_rdata;
            end
        end
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic send(input byte unsigned b, input bit stop_ok);
        logic [31:0] dummy;
        idle(4);
        send_frame(b, stop_ok, 1'b0, -1, dummy);
        m_frame(b, stop_ok);
    endtask

    initial begin
        logic [31:0] d;
        int          n;
        bit          saw;

        reset         = 1'b1;
        rxd           = 1'b1;
        bus.mem_addr  = 32'd0;
        bus.mem_wdata = 32'd0;
        bus.mem_wmask = 4'h0;
        bus.mem_rstrb = 1'b0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // reset state
        check("rst_rdata", bus.mem_rdata, 32'd0);
        check("rst_irq", {31'd0, rx_irq}, 32'd0);
        check("rst_busy", {31'd0, rx_busy}, 32'd0);
        rd_status("rst_status");
        rd_ctrl("rst_ctrl");

        // single byte
        send(8'hA5, 1'b1);
        rd_status("a5_status");
        rd_data("a5_data");
        @(posedge clk); #1;
        check("rdata_idle_zero", bus.mem_rdata, 32'd0);
        rd_status("a5_status_after");
        rd_data("empty_data");

        // overflow
        for (int i = 1; i <= 5; i++) send(8'(i), 1'b1);
        rd_status("ovf_status");
        bus_read(32'h2000_3000, d);
        check("other_page_zero", d, 32'd0);
        for (int i = 0; i < 5; i++) rd_data("ovf_drain");
        wr_status(32'h4);
        rd_status("ovf_cleared");

        // glitch on the line
        idle(4);
        rxd = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rxd = 1'b1;
        check("glitch_busy", {31'd0, rx_busy}, 32'd1);
        n = 0;
        while (rx_busy && n < 20) begin @(posedge clk); #1; n++; end
        check("glitch_recover", {31'd0, n <= HALF + 3}, 32'd1);
        rd_status("glitch_status");

        // frame error, line held low afterwards
        idle(4);
        send_frame(8'h3C, 1'b0, 1'b0, -1, d);
        m_frame(8'h3C, 1'b0);
        saw = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (rx_busy) saw = 1'b1;
        end
        check("held_low_no_frame", {31'd0, saw}, 32'd0);
        rd_status("fe_status");
        wr_status(32'h8);
        rd_status("fe_cleared");

        // interrupt
        wr_ctrl(32'h3);
        send(8'h9E, 1'b1);
        check("irq_set", {31'd0, rx_irq}, 32'd1);
        rd_data("irq_data");
        check("irq_clear", {31'd0, rx_irq}, 32'd0);

        // full FIFO, pop coincides with stop sample
        for (int i = 0; i < DEPTH; i++) send(8'(8'h40 + i), 1'b1);
        idle(4);
        send_frame(8'hC3, 1'b1, 1'b1, -1, d);
        check("coincide_pop", d, m_pop());
        m_frame(8'hC3, 1'b1);
        rd_status("coincide_status");
        for (int i = 0; i < DEPTH; i++) rd_data("coincide_drain");

        // reset mid-DATA
        send(8'h11, 1'b1);
        idle(4);
        send_frame(8'h77, 1'b1, 1'b0, 40, d);
        m_reset();
        idle(4);
        rd_status("mid_reset_status");
        rd_ctrl("mid_reset_ctrl");
        send(8'h55, 1'b1);
        rd_data("after_reset_data");

        // disabled receiver keeps contents, ignores line
        send(8'h2B, 1'b1);
        wr_ctrl(32'h0);
        send(8'hD4, 1'b1);
        rd_ctrl("disabled_ctrl");
        rd_status("disabled_status");
        rd_data("disabled_data");
        wr_ctrl(32'h1);

        // randomized traffic
        for (int it = 0; it < 16; it++) begin
            byte unsigned b;
            bit           ok;
            b  = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 5) == 0) wr_ctrl({30'd0, 1'($urandom_range(0, 1)), 1'b1});
            send(b, ok);
            check("rnd_irq", {31'd0, rx_irq}, {31'd0, (mq.size() != 0) && m_ien});
            n = $urandom_range(0, 2);
            for (int r = 0; r < n; r++) rd_data("rnd_data");
            if ($urandom_range(0, 1) == 1) rd_status("rnd_status");
            if ($urandom_range(0, 3) == 0) wr_status({28'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'b00});
        end
        rd_status("final_status");
        for (int i = 0; i < DEPTH; i++) rd_data("final_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
